// File: rtl/ro_sensor_pkg.sv
// ro_sensor_pkg: shared types and limits for the ring-oscillator sensor bank.
// Holds the measurement FSM state enum, the default count type and the
// minimum legal oscillator length and settle time.
package ro_sensor_pkg;

    localparam int RO_MIN_STAGES = 3;
    localparam int RO_MIN_SETTLE = 3;
    localparam int RO_CNT_W      = 16;

    typedef logic [RO_CNT_W-1:0] ro_count_t;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        MEASURE,
        REPORT
    } ro_state_e;

endpackage

// File: rtl/ro_sensor_bank_cell.sv
// ro_cell: one gated ring oscillator (AND enable gate + STAGES inverters).
// Ports: gate (enable, low = stopped, output held low), osc (raw output).
// Synthesis (SYNTHESIS defined) gets keep-attributed zero-delay inverters;
// simulation models each inverter with STAGE_DELAY_PS of delay.
`timescale 1ns/1ps
module ro_cell #(
    parameter int STAGES         = 3,
    parameter int STAGE_DELAY_PS = 10000
) (
    input  logic gate,
    output logic osc
);

    (* keep = "true" *) logic [STAGES-1:0] inv;
    (* keep = "true" *) logic              en;

    // Odd inverter count: with gate low the tail settles high, so the
    // ring starts the moment gate rises.
    assign en  = gate & inv[STAGES-1];
    assign osc = en;

`ifdef SYNTHESIS
    assign inv[0] = ~en;
    for (genvar i = 1; i < STAGES; i++) begin : g_inv
        assign inv[i] = ~inv[i-1];
    end
`else
    // Delay written in ns to match the file timescale.
    assign #(STAGE_DELAY_PS / 1000.0) inv[0] = ~en;
    for (genvar i = 1; i < STAGES; i++) begin : g_inv
        assign #(STAGE_DELAY_PS / 1000.0) inv[i] = ~inv[i-1];
    end
`endif

endmodule

// File: rtl/ro_sensor_bank.sv
// ro_sensor_bank: NUM_CH gated ring oscillators with windowed edge counters.
// Ports: clock/reset (sync, active high); io_start + io_windowCycles +
//   io_chEnable start a run; io_thrLow/io_thrHigh band; io_alarmClear;
//   io_busy, io_done pulse, io_count (ch i at [i*CNT_W +: CNT_W]), io_alarm.
// Define RO_SENSOR_ALARM_EN to build the sticky out-of-band alarm logic.
`timescale 1ns/1ps
module ro_sensor_bank
    import ro_sensor_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int STAGES         = 3,
    parameter int WIN_W          = 16,
    parameter int CNT_W          = 16,
    parameter int SETTLE_CYCLES  = 4,
    parameter int STAGE_DELAY_PS = 10000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    io_start,
    input  logic [WIN_W-1:0]        io_windowCycles,
    input  logic [NUM_CH-1:0]       io_chEnable,
    input  logic [CNT_W-1:0]        io_thrLow,
    input  logic [CNT_W-1:0]        io_thrHigh,
    input  logic                    io_alarmClear,
    output logic                    io_busy,
    output logic                    io_done,
    output logic [NUM_CH*CNT_W-1:0] io_count,
    output logic [NUM_CH-1:0]       io_alarm
);

    // Illegal settings are pulled up to the nearest working value.
    localparam int SETTLE_EFF = (SETTLE_CYCLES < RO_MIN_SETTLE) ?
                                RO_MIN_SETTLE : SETTLE_CYCLES;
    localparam int STAGES_EFF = (STAGES < RO_MIN_STAGES) ?
                                RO_MIN_STAGES : (STAGES | 1);
    localparam int SET_W = $clog2(SETTLE_EFF + 1);
    localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ro_state_e          state_q, state_d;
    logic [TMR_W-1:0]   tmr_q;
    logic               tmr_zero;
    logic [WIN_W-1:0]   win_q;
    logic [NUM_CH-1:0]  mask_q, mask_d, gate_q, osc;
    logic [NUM_CH-1:0]  s1_q, s2_q, prev_q, rise;
    logic [CNT_W-1:0]   cnt_q [NUM_CH];
    logic [CNT_W-1:0]   cnt_d [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ro_cell #(
            .STAGES         (STAGES_EFF),
            .STAGE_DELAY_PS (STAGE_DELAY_PS)
        ) u_cell (
            .gate (gate_q[i]),
            .osc  (osc[i])
        );
    end

    // 2-FF synchroniser plus edge-detect flop per channel.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
        end else begin
            s1_q   <= osc;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign rise     = s2_q & ~prev_q;
    assign tmr_zero = (tmr_q == '0);
    assign mask_d   = (state_q == IDLE && io_start) ? io_chEnable : mask_q;

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (io_start) state_d = SETTLE;
            SETTLE:  if (tmr_zero)
                         state_d = (win_q == '0) ? REPORT : MEASURE;
            MEASURE: if (tmr_zero) state_d = REPORT;
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One down-counter times both SETTLE and MEASURE.
    always_ff @(posedge clock) begin
        if (reset) begin
            tmr_q  <= '0;
            win_q  <= '0;
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
            if (state_q == IDLE && io_start) begin
                tmr_q <= TMR_W'(SETTLE_EFF - 1);
                win_q <= io_windowCycles;
            end else if (state_q == SETTLE && tmr_zero && win_q != '0) begin
                tmr_q <= TMR_W'(win_q) - 1'b1;
            end else if (!tmr_zero) begin
                tmr_q <= tmr_q - 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (state_q == SETTLE)
                cnt_d[i] = '0;
            else if (state_q == MEASURE && mask_q[i] && rise[i] &&
                     cnt_q[i] != CNT_MAX)
                cnt_d[i] = cnt_q[i] + 1'b1;
        end
    end

    // Outputs are registered off the next state so they line up with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
            gate_q   <= '0;
            io_busy  <= 1'b0;
            io_done  <= 1'b0;
            io_count <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
            gate_q  <= (state_d == SETTLE || state_d == MEASURE) ?
                       mask_d : '0;
            io_busy <= (state_d != IDLE);
            io_done <= (state_d == REPORT);
            if (state_d == REPORT) begin
                for (int i = 0; i < NUM_CH; i++)
                    io_count[i*CNT_W +: CNT_W] <= cnt_d[i];
            end
        end
    end

`ifdef RO_SENSOR_ALARM_EN
    logic [NUM_CH-1:0] alarm_set;

    always_comb begin
        alarm_set = '0;
        if (state_d == REPORT) begin
            for (int i = 0; i < NUM_CH; i++)
                alarm_set[i] = mask_q[i] &&
                               (cnt_d[i] < io_thrLow ||
                                cnt_d[i] > io_thrHigh);
        end
    end

    // A set in the same cycle as a clear wins.
    always_ff @(posedge clock) begin
        if (reset) io_alarm <= '0;
        else       io_alarm <= (io_alarmClear ? '0 : io_alarm) | alarm_set;
    end
`else
    logic unused_alarm;
    assign unused_alarm = ^{io_thrLow, io_thrHigh, io_alarmClear};
    assign io_alarm     = '0;
`endif

endmodule
